// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared defaults, edge encoding and counter sizing for the debouncer
package debounce_pkg;

    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_SYNC_STAGES   = 2;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10
    } edge_e;

    // Counter only has to reach STABLE_CYCLES-1; never narrower than one bit.
    function automatic int cnt_width(input int stable);
        return (stable < 1) ? 1 : $clog2(stable + 1);
    endfunction

endpackage

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - plain flop-chain synchronizer for a single asynchronous bit
module debounce_sync #(
    parameter int   STAGES      = 2,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_chain <= {STAGES{RESET_VALUE}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/debounce.sv
// rtl/debounce.sv - key debouncer: synchronizer, stability counter, registered level and edge pulses
module debounce
    import debounce_pkg::*;
#(
    parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter logic RESET_VALUE   = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall
);

    localparam int             CW     = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0]  C_LAST = CW'(STABLE_CYCLES - 1);

    logic          w_sync_in;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          r_out;
    logic          w_out_nxt;
    logic          r_rise;
    logic          r_fall;
    edge_e         w_edge;

    debounce_sync #(
        .STAGES      (SYNC_STAGES),
        .RESET_VALUE (RESET_VALUE)
    ) u_sync (
        .clock   (clock),
        .reset   (reset),
        .i_async (in),
        .o_sync  (w_sync_in)
    );

    // The counter restarts whenever the synchronized input agrees with out,
    // so it tops out at C_LAST and cannot wrap.
    always_comb begin
        w_count_nxt = '0;
        w_out_nxt   = r_out;
        w_edge      = EDGE_NONE;
        if (w_sync_in != r_out) begin
            if (r_count == C_LAST) begin
                w_out_nxt = w_sync_in;
                w_edge    = w_sync_in ? EDGE_RISE : EDGE_FALL;
            end else begin
                w_count_nxt = r_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_out   <= RESET_VALUE;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_out   <= w_out_nxt;
            r_rise  <= (w_edge == EDGE_RISE);
            r_fall  <= (w_edge == EDGE_FALL);
        end
    end

    assign out  = r_out;
    assign rise = r_rise;
    assign fall = r_fall;

endmodule

// File: tb/tb_debounce.sv
// tb/tb_debounce.sv - randomized self-checking bench for debounce against a sample-window reference model
module tb_debounce;

    localparam int STABLE = 4;
    localparam int SYNC   = 2;
    localparam bit RV     = 1'b0;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic in    = 1'b1;
    logic out;
    logic rise;
    logic fall;

    int n_tests = 0;
    int n_fail  = 0;

    debounce #(
        .STABLE_CYCLES (STABLE),
        .SYNC_STAGES   (SYNC),
        .RESET_VALUE   (RV)
    ) dut (
        .clock (clock),
        .reset (reset),
        .in    (in),
        .out   (out),
        .rise  (rise),
        .fall  (fall)
    );

    always #5 clock = ~clock;

    // Reference: raw samples per edge since the last reset; out flips once the
    // last STABLE synchronized samples all differ from it and no flip happened
    // within that window.
    bit hist [0:8191];
    int n_edge;
    int last_chg;
    bit m_out, m_rise, m_fall;

    function automatic bit sample_at(input int idx);
        return (idx < 1) ? RV : hist[idx];
    endfunction

    task automatic model_reset();
        n_edge   = 0;
        last_chg = 0;
        m_out    = RV;
        m_rise   = 1'b0;
        m_fall   = 1'b0;
    endtask

    task automatic model_edge(input bit v);
        bit all_diff;
        n_edge++;
        hist[n_edge] = v;
        m_rise   = 1'b0;
        m_fall   = 1'b0;
        all_diff = 1'b1;
        for (int k = 0; k < STABLE; k++)
            if (sample_at(n_edge - SYNC - k) == m_out) all_diff = 1'b0;
        if (all_diff && (n_edge - last_chg >= STABLE)) begin
            m_out    = ~m_out;
            m_rise   = m_out;
            m_fall   = ~m_out;
            last_chg = n_edge;
        end
    endtask

    task automatic cycle(input bit v);
        in = v;
        @(posedge clock);
        if (!reset) model_edge(v);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in    = 1'b1;
        #3;
        n_tests++;
        if ({out, rise, fall} !== {RV, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_immediate: out/rise/fall=%b%b%b required %b00", out, rise, fall, RV);
        end
        repeat (3) @(posedge clock);
        #1;
        n_tests++;
        if ({out, rise, fall} !== {RV, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_held: out/rise/fall=%b%b%b required %b00", out, rise, fall, RV);
        end
        #2;
        in    = 1'b0;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0);
            n_tests++;
            if ({out, rise, fall} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_release c%0d: out/rise/fall=%b%b%b required 000", i, out, rise, fall);
            end
        end
    endtask

    task automatic test_glitch();
        bit pat [0:7] = '{1, 1, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            cycle(pat[i]);
            n_tests++;
            if ({out, rise, fall} !== 3'b000 || {out, rise, fall} !== {m_out, m_rise, m_fall}) begin
                n_fail++;
                $display("FAIL glitch c%0d: out/rise/fall=%b%b%b required 000 (model %b%b%b)",
                         i, out, rise, fall, m_out, m_rise, m_fall);
            end
        end
    endtask

    task automatic test_press();
        int hit = -1;
        repeat (4) cycle(1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1);
            if (rise && hit < 0) hit = i;
            n_tests++;
            if ({out, rise, fall} !== {m_out, m_rise, m_fall}) begin
                n_fail++;
                $display("FAIL press c%0d: out/rise/fall=%b%b%b required %b%b%b",
                         i, out, rise, fall, m_out, m_rise, m_fall);
            end
        end
        n_tests++;
        if (hit != 5 || out !== 1'b1) begin
            n_fail++;
            $display("FAIL press_latency: rise at edge %0d out=%b, required edge 5 out=1", hit, out);
        end
    endtask

    task automatic test_release();
        int hit = -1;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0);
            if (fall && hit < 0) hit = i;
            n_tests++;
            if ({out, rise, fall} !== {m_out, m_rise, m_fall}) begin
                n_fail++;
                $display("FAIL release c%0d: out/rise/fall=%b%b%b required %b%b%b",
                         i, out, rise, fall, m_out, m_rise, m_fall);
            end
        end
        n_tests++;
        if (hit != 5 || out !== 1'b0) begin
            n_fail++;
            $display("FAIL release_latency: fall at edge %0d out=%b, required edge 5 out=0", hit, out);
        end
    endtask

    task automatic test_alternating();
        int rises = 0;
        for (int w = 1; w <= 9; w++) begin
            for (int lv = 1; lv >= 0; lv--) begin
                for (int j = 0; j < w; j++) begin
                    cycle(lv[0]);
                    if (rise) rises++;
                    n_tests++;
                    if ({out, rise, fall} !== {m_out, m_rise, m_fall}) begin
                        n_fail++;
                        $display("FAIL alternating w%0d lv%0d: out/rise/fall=%b%b%b required %b%b%b",
                                 w, lv, out, rise, fall, m_out, m_rise, m_fall);
                    end
                end
            end
        end
        repeat (8) begin
            cycle(1'b0);
            if (rise) rises++;
        end
        n_tests++;
        if (rises != 6 || out !== 1'b0) begin
            n_fail++;
            $display("FAIL alternating_summary: rises=%0d out=%b, required rises=6 out=0", rises, out);
        end
    endtask

    task automatic test_random();
        bit lvl = 1'b1;
        for (int s = 0; s < 150; s++) begin
            int w = $urandom_range(1, 8);
            for (int j = 0; j < w; j++) begin
                cycle(lvl);
                n_tests++;
                if ({out, rise, fall} !== {m_out, m_rise, m_fall} || (rise && fall)) begin
                    n_fail++;
                    $display("FAIL random s%0d: out/rise/fall=%b%b%b required %b%b%b",
                             s, out, rise, fall, m_out, m_rise, m_fall);
                end
            end
            lvl = ~lvl;
        end
    endtask

    task automatic test_reset_mid();
        int hit = -1;
        repeat (8) cycle(1'b0);
        repeat (4) cycle(1'b1);
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({out, rise, fall} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid_async: out/rise/fall=%b%b%b required 000", out, rise, fall);
        end
        model_reset();
        @(posedge clock);
        #3;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1);
            if (rise && hit < 0) hit = i;
            n_tests++;
            if ({out, rise, fall} !== {m_out, m_rise, m_fall}) begin
                n_fail++;
                $display("FAIL reset_mid c%0d: out/rise/fall=%b%b%b required %b%b%b",
                         i, out, rise, fall, m_out, m_rise, m_fall);
            end
        end
        n_tests++;
        if (hit != 5) begin
            n_fail++;
            $display("FAIL reset_mid_latency: rise at edge %0d, required edge 5", hit);
        end
    endtask

    task automatic test_reset_during_pulse();
        bit seen = 1'b0;
        repeat (10) cycle(1'b0);
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle(1'b1);
            seen = rise;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL pulse_wait: rise=0 after 10 edges, required 1");
        end
        #1;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({out, rise, fall} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_pulse_clear: out/rise/fall=%b%b%b required 000", out, rise, fall);
        end
        model_reset();
        @(posedge clock);
        #3;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0);
            n_tests++;
            if ({out, rise, fall} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_pulse_after c%0d: out/rise/fall=%b%b%b required 000", i, out, rise, fall);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_glitch();
        test_press();
        test_release();
        test_alternating();
        test_random();
        test_reset_mid();
        test_reset_during_pulse();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/debounce.md
Name: debounce

Overview:
Single-bit input debouncer for mechanical key/button signals such as the "hit" key. The raw asynchronous input passes through a synchronizer. The output changes only after the synchronized input has held a new level for a programmable number of consecutive clock cycles. It sits between the board input pin and game/control logic, and also provides one-cycle edge pulses on each accepted transition.

Parameters:
STABLE_CYCLES, 4, consecutive synchronized samples at the new level required before out changes; legal range ≥ 1.
SYNC_STAGES, 2, number of synchronizer flops on in; legal range ≥ 2.
RESET_VALUE, 1'b0, level loaded into the synchronizer flops and out on reset.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
in     input  1  raw, bouncy, asynchronous key input.
out    output 1  debounced level (registered).
rise   output 1  one-cycle pulse, asserted in the cycle where out goes 0→1.
fall   output 1  one-cycle pulse, asserted in the cycle where out goes 1→0.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (ports clock and reset).
- Reset asserted, any time: the following are forced immediately, independent of clock:
  - synchronizer flops = RESET_VALUE
  - out = RESET_VALUE
  - counter = 0
  - rise = 0, fall = 0
- First clock edge after reset release: normal operation; no edge pulse is generated by reset itself.
- Synchronizer: SYNC_STAGES-deep flop chain on in. Its last stage is sync_in. No logic between stages.
- Counter: width $clog2(STABLE_CYCLES+1), saturating; it can never wrap. Each rising edge:
  - sync_in == out: counter ← 0; out holds.
  - sync_in != out and counter < STABLE_CYCLES-1: counter ← counter+1.
  - sync_in != out and counter == STABLE_CYCLES-1: out ← sync_in; counter ← 0; rise/fall asserted per direction.
- Any return of sync_in to the current out level, even for one cycle, clears the counter. Glitches shorter than STABLE_CYCLES sampled cycles never reach out.
- Latency: let edge E0 be the edge on which the first synchronizer flop captures a new level. If that level is held, out changes at edge E0 + SYNC_STAGES + STABLE_CYCLES − 1. That is 5 edges with defaults.
- rise/fall are registered and aligned with the out transition. They are high for exactly one cycle and are never both high.
- STABLE_CYCLES = 1: out follows sync_in with one extra register stage.
- No combinational path from in to any output.

Decomposition:
- No shared package needed.
- Optional sub-module sync_2ff (parameterised depth, reset value) for the synchronizer chain, reusable for other async inputs.
- Counter and output logic stay in debounce.

Test Plan (clock period 10, defaults):
- Reset: assert reset with in = 1 → out = 0, rise = fall = 0 immediately. Release reset with in = 0 → out stays 0, no pulses.
- Short glitch: in high for 2 cycles (t = 10..30), then low for 3 cycles → out stays 0 throughout; counter never reaches 3.
- Accepted press: in high for 4 cycles (t = 60..100) → out rises exactly 5 edges after in is first sampled high. rise is high for one cycle at that edge; fall = 0.
- Accepted release: with out = 1, hold in low for 5 cycles (t = 100..150) → out falls 5 edges after the low is first sampled, with a single-cycle fall pulse.
- Long alternating pattern: in toggles with high/low widths of 1, 2, …, 9 cycles → out changes only for widths ≥ 4. It settles to the final in value after the final toggle plus 5 edges. rise count equals accepted rising transitions.
- Reset mid-count: in goes high, and reset is asserted 2 cycles into the count → out = 0 and counter = 0 asynchronously. After release with in still high, a full 5-edge latency is required before out = 1.
